// File: rtl/dft_seq_ctrl_if.sv
// rtl/dft_seq_ctrl_if.sv - load, compute and result-handshake bus of the DFT sequencing controller
interface dft_seq_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_adr;
    logic              cache_wr_en;
    logic [ADDR_W-1:0] cache_wr_adr;
    logic [ADDR_W-1:0] n_idx;
    logic [ADDR_W-1:0] k_idx;
    logic [ADDR_W-1:0] tw_adr;
    logic              acc_clear;
    logic              acc_en;
    logic              result_valid;
    logic              result_ready;

    modport master (
        output mem_rd_en, mem_rd_adr, cache_wr_en, cache_wr_adr,
        output n_idx, k_idx, tw_adr, acc_clear, acc_en, result_valid,
        input  result_ready
    );

    modport slave (
        input  mem_rd_en, mem_rd_adr, cache_wr_en, cache_wr_adr,
        input  n_idx, k_idx, tw_adr, acc_clear, acc_en, result_valid,
        output result_ready
    );
endinterface

// File: rtl/dft_seq_ctrl.sv
// rtl/dft_seq_ctrl.sv - DFT load/compute/drain/result sequencer; DFT_SEQ_CTRL_PERF_CNT_EN adds cycle_cnt
module dft_seq_ctrl #(
    parameter int ADDR_W   = 12,
    parameter int PIPE_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              start,
    input  logic [ADDR_W-1:0] sample_num,
    output logic              busy,
    output logic              done,
    output logic [31:0]       cycle_cnt,
    dft_seq_ctrl_if.master    bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_LOAD_DRAIN, S_COMPUTE, S_DRAIN, S_RESULT, S_DONE
    } state_e;

    localparam logic [3:0] DRAIN_LAST = 4'(PIPE_LAT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] n_q, n_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [ADDR_W-1:0] tw_q, tw_d;
    logic [3:0]        dcnt_q, dcnt_d;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_adr_q;

    logic [ADDR_W-1:0] last_idx;
    logic [ADDR_W:0]   tw_sum;
    logic              tw_wrap;
    logic [ADDR_W-1:0] tw_next;
    logic              start_ok;

    assign last_idx = len_q - 1'b1;
    assign start_ok = start && (sample_num != '0);
    // tw + k < 2N always, so one conditional subtract keeps the index modulo N
    assign tw_sum   = {1'b0, tw_q} + {1'b0, k_q};
    assign tw_wrap  = tw_sum >= {1'b0, len_q};
    assign tw_next  = tw_q + k_q - (tw_wrap ? len_q : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            n_q      <= '0;
            k_q      <= '0;
            tw_q     <= '0;
            dcnt_q   <= '0;
            wr_en_q  <= 1'b0;
            wr_adr_q <= '0;
        end else if (ce) begin
            state_q  <= state_d;
            len_q    <= len_d;
            n_q      <= n_d;
            k_q      <= k_d;
            tw_q     <= tw_d;
            dcnt_q   <= dcnt_d;
            wr_en_q  <= (state_q == S_LOAD);
            wr_adr_q <= (state_q == S_LOAD) ? n_q : wr_adr_q;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        n_d     = n_q;
        k_d     = k_q;
        tw_d    = tw_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_LOAD;
                    len_d   = sample_num;
                    n_d     = '0;
                    k_d     = '0;
                    tw_d    = '0;
                end
            end
            S_LOAD: begin
                if (n_q == last_idx) begin
                    state_d = S_LOAD_DRAIN;
                    n_d     = '0;
                end else begin
                    n_d = n_q + 1'b1;
                end
            end
            S_LOAD_DRAIN: begin
                state_d = S_COMPUTE;
                n_d     = '0;
                k_d     = '0;
                tw_d    = '0;
            end
            S_COMPUTE: begin
                if (n_q == last_idx) begin
                    state_d = S_DRAIN;
                    dcnt_d  = '0;
                end else begin
                    n_d  = n_q + 1'b1;
                    tw_d = tw_next;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == DRAIN_LAST) state_d = S_RESULT;
                else                      dcnt_d  = dcnt_q + 1'b1;
            end
            S_RESULT: begin
                if (bus.result_ready) begin
                    if (k_q == last_idx) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_COMPUTE;
                        k_d     = k_q + 1'b1;
                        n_d     = '0;
                        tw_d    = '0;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // strobes are gated by ce so a frozen cycle never repeats a read, write or accumulate
    assign busy             = (state_q != S_IDLE);
    assign done             = ce && (state_q == S_DONE);
    assign bus.mem_rd_en    = ce && (state_q == S_LOAD);
    assign bus.mem_rd_adr   = (state_q == S_LOAD) ? n_q : '0;
    assign bus.cache_wr_en  = ce && wr_en_q;
    assign bus.cache_wr_adr = wr_adr_q;
    assign bus.n_idx        = (state_q == S_COMPUTE) ? n_q : '0;
    assign bus.k_idx        = (state_q == S_COMPUTE || state_q == S_DRAIN || state_q == S_RESULT) ? k_q : '0;
    assign bus.tw_adr       = (state_q == S_COMPUTE) ? tw_q : '0;
    assign bus.acc_en       = ce && (state_q == S_COMPUTE);
    assign bus.acc_clear    = ce && (state_q == S_COMPUTE) && (n_q == '0);
    assign bus.result_valid = (state_q == S_RESULT);

`ifdef DFT_SEQ_CTRL_PERF_CNT_EN
    logic [31:0] cyc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
        end else if (ce) begin
            if (state_q == S_IDLE && start_ok)                 cyc_q <= '0;
            else if (state_q != S_IDLE && cyc_q != '1)         cyc_q <= cyc_q + 1'b1;
        end
    end

    assign cycle_cnt = cyc_q;
`else
    assign cycle_cnt = '0;
`endif
endmodule

// File: tb/tb_dft_seq_ctrl.sv
// tb/tb_dft_seq_ctrl.sv - self-checking bench for dft_seq_ctrl against a position-based timeline model
module tb_dft_seq_ctrl;
    localparam int AW = 12;
    localparam int PL = 3;

    logic          clk = 1'b0;
    logic          rst, ce, start;
    logic [AW-1:0] sample_num;
    logic          busy, done;
    logic [31:0]   cycle_cnt;

    dft_seq_ctrl_if #(.ADDR_W(AW)) bus ();

    dft_seq_ctrl #(.ADDR_W(AW), .PIPE_LAT(PL)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .start      (start),
        .sample_num (sample_num),
        .busy       (busy),
        .done       (done),
        .cycle_cnt  (cycle_cnt),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc_no = 0;
    bit obs_done;

    // model: m_pos counts productive cycles since an accepted start (0 = idle)
    int          m_pos = 0;
    int          m_n   = 0;
    logic [31:0] m_cnt = '0;

    int rnd_mode = 0;
    int stall_k = -1, stall_left = 0;
    int frz_k = -1, frz_n = -1, frz_left = 0;
    int abort_k = -1;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc_no);
    endtask

    // phase: 0 idle, 1 load, 2 load drain, 3 compute, 4 drain, 5 result, 6 done
    function automatic void model_phase(output int ph, output int kk, output int r);
        int len, last, c;
        len  = m_n + PL + 1;
        last = m_n + 2 + m_n * len;
        kk = 0;
        r  = 0;
        if (m_pos == 0)                 ph = 0;
        else if (m_pos <= m_n)          ph = 1;
        else if (m_pos == m_n + 1)      ph = 2;
        else if (m_pos == last)         ph = 6;
        else begin
            c  = m_pos - (m_n + 2);
            kk = c / len;
            r  = c % len;
            if (r < m_n)           ph = 3;
            else if (r < m_n + PL) ph = 4;
            else                   ph = 5;
        end
    endfunction

    task automatic check_model();
        int  ph, kk, r;
        bit  wr_e;
        logic [31:0] exp_cnt;
        model_phase(ph, kk, r);
        chk("busy", busy, m_pos != 0);
        chk("done", done, (ph == 6) && ce);
        chk("mem_rd_en", bus.mem_rd_en, (ph == 1) && ce);
        if (ph == 1 && ce) chk("mem_rd_adr", bus.mem_rd_adr, m_pos - 1);
        wr_e = (m_pos >= 2) && (m_pos <= m_n + 1);
        chk("cache_wr_en", bus.cache_wr_en, wr_e && ce);
        if (wr_e && ce) chk("cache_wr_adr", bus.cache_wr_adr, m_pos - 2);
        chk("acc_en", bus.acc_en, (ph == 3) && ce);
        chk("acc_clear", bus.acc_clear, (ph == 3) && (r == 0) && ce);
        if (ph == 3) begin
            chk("n_idx", bus.n_idx, r);
            chk("k_idx_comp", bus.k_idx, kk);
            chk("tw_adr", bus.tw_adr, (r * kk) % m_n);
        end
        chk("result_valid", bus.result_valid, ph == 5);
        if (ph == 5) chk("k_idx_res", bus.k_idx, kk);
`ifdef DFT_SEQ_CTRL_PERF_CNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = '0;
`endif
        chk("cycle_cnt", cycle_cnt, exp_cnt);
        obs_done = done;
    endtask

    task automatic model_update();
        int ph, kk, r;
        model_phase(ph, kk, r);
        if (rst) begin
            m_pos = 0;
            m_cnt = '0;
        end else if (ce) begin
            if (m_pos != 0 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (m_pos == 0) begin
                if (start && sample_num != '0) begin
                    m_pos = 1;
                    m_n   = int'(sample_num);
                    m_cnt = '0;
                end
            end else if (ph == 5 && !bus.result_ready) begin
                m_pos = m_pos;
            end else if (ph == 6) begin
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic cyc();
        #1;
        check_model();
        @(posedge clk);
        model_update();
        cyc_no++;
        #1;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd"}, {bus.mem_rd_en, bus.mem_rd_adr}, 0);
        chk({tag, "_wr"}, {bus.cache_wr_en, bus.cache_wr_adr}, 0);
        chk({tag, "_idx"}, {bus.n_idx, bus.k_idx, bus.tw_adr}, 0);
        chk({tag, "_acc"}, {bus.acc_en, bus.acc_clear, bus.result_valid}, 0);
        chk({tag, "_cnt"}, cycle_cnt, 0);
    endtask

    task automatic run_tx(input int n, output int lat);
        int ph, kk, r, t, guard;
        lat = -1;
        rst = 1'b0;
        ce = 1'b1;
        bus.result_ready = 1'b1;
        start = 1'b1;
        sample_num = AW'(n);
        cyc();
        start = 1'b0;
        t = 0;
        guard = 0;
        while (m_pos != 0 && guard < 5000) begin
            ce = 1'b1;
            bus.result_ready = 1'b1;
            start = 1'b0;
            if (rnd_mode != 0) begin
                ce = ($urandom % 10) != 0;
                bus.result_ready = ($urandom % 3) != 0;
                start = ($urandom % 5) == 0;
                sample_num = AW'($urandom);
            end
            model_phase(ph, kk, r);
            if (stall_k >= 0 && ph == 5 && kk == stall_k && stall_left > 0) begin
                bus.result_ready = 1'b0;
                stall_left--;
            end
            if (frz_k >= 0 && ph == 3 && kk == frz_k && r == frz_n && frz_left > 0) begin
                ce = 1'b0;
                frz_left--;
            end
            if (abort_k >= 0 && ph == 3 && kk == abort_k && r == 2) rst = 1'b1;
            t++;
            guard++;
            cyc();
            if (obs_done && lat < 0) lat = t;
        end
        if (guard >= 5000) chk("timeout", 1, 0);
        rst = 1'b0;
        ce = 1'b1;
        start = 1'b0;
        bus.result_ready = 1'b0;
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        ce = 1'b0;
        start = 1'b0;
        sample_num = '0;
        bus.result_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc();
        cyc();
        rst = 1'b0;
        ce = 1'b1;
        chk_zero("reset");
        cyc();

        run_tx(4, lat);
        chk("lat_n4", lat, 38);
`ifdef DFT_SEQ_CTRL_PERF_CNT_EN
        chk("perf_n4", cycle_cnt, 38);
`else
        chk("perf_off", cycle_cnt, 0);
`endif
        cyc();

        stall_k = 1;
        stall_left = 5;
        run_tx(3, lat);
        chk("lat_n3_stall", lat, 31);
        stall_k = -1;

        frz_k = 1;
        frz_n = 2;
        frz_left = 2;
        run_tx(4, lat);
        chk("lat_n4_freeze", lat, 40);
        frz_k = -1;

        start = 1'b1;
        sample_num = '0;
        cyc();
        start = 1'b0;
        cyc();
        chk("n0_ignored", busy, 0);

        abort_k = 1;
        run_tx(5, lat);
        abort_k = -1;
        chk("abort_no_done", lat, 64'hFFFF_FFFF_FFFF_FFFF);
        chk_zero("abort");
        cyc();

        run_tx(1, lat);
        chk("lat_n1", lat, 8);

        rnd_mode = 1;
        for (int i = 0; i < 6; i++) begin
            run_tx($urandom_range(1, 7), lat);
            cyc();
        end
        rnd_mode = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
